pkt_gen_tx_scheduler: RTL

Replay sequencer between the SRAM-FIFO output stage (AXI4-Stream master) and the egress MAC/output queue.
- Gates the stream on packet boundaries under software control: start/stop, packet-count limit and inter-packet gap (IPG) in clock cycles.
- Exports transmit statistics.
- Datapath is zero-latency combinational pass-through; only handshake gating is sequential.

---
 rtl/pkt_gen_tx_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pkt_gen_tx_scheduler.sv
// Packet-boundary replay gate between the SRAM-FIFO stream and the egress MAC, with transmit statistics.
// Optional byte counter enabled by defining PKT_GEN_SCHED_BYTE_CNT_EN.
module pkt_gen_tx_scheduler #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 64,
  parameter int TDEST_WIDTH = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int IPG_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [8*TDATA_WIDTH-1:0] s_tdata,
  input  logic [TDATA_WIDTH-1:0]   s_tkeep,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  input  logic [TDEST_WIDTH-1:0]   s_tdest,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [8*TDATA_WIDTH-1:0] m_tdata,
  output logic [TDATA_WIDTH-1:0]   m_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  output logic [TDEST_WIDTH-1:0]   m_tdest,
  input  logic                     start,
  input  logic                     stop,
  input  logic [CNT_WIDTH-1:0]     pkt_limit,
  input  logic [IPG_WIDTH-1:0]     ipg_cycles,
`ifdef PKT_GEN_SCHED_BYTE_CNT_EN
  output logic [CNT_WIDTH-1:0]     byte_cnt,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     pkt_cnt,
  output logic [CNT_WIDTH-1:0]     word_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] limit_q;
  logic [IPG_WIDTH-1:0] ipg_q;
  logic [IPG_WIDTH-1:0] gap_cnt;
  logic                 stop_pending;
  logic                 in_pkt;
  logic                 sending;
  logic                 beat;
  logic                 eop;
  logic [CNT_WIDTH:0]   pkt_cnt_p1;
  logic                 limit_hit;

  assign m_tdata  = s_tdata;
  assign m_tkeep  = s_tkeep;
  assign m_tuser  = s_tuser;
  assign m_tdest  = s_tdest;
  assign m_tlast  = s_tlast;

  // Gating also on reset keeps the handshake closed while the state register is being reset.
  assign sending  = (state == SEND) & ~reset;
  assign m_tvalid = s_tvalid & sending;
  assign s_tready = m_tready & sending;

  assign beat       = m_tvalid & m_tready;
  assign eop        = beat & s_tlast;
  assign pkt_cnt_p1 = {1'b0, pkt_cnt} + (CNT_WIDTH+1)'(1);
  assign limit_hit  = (limit_q != '0) && (pkt_cnt_p1 == {1'b0, limit_q});

  assign busy = (state == SEND) || (state == GAP);
  assign done = (state == DONE);

`ifdef PKT_GEN_SCHED_BYTE_CNT_EN
  logic [CNT_WIDTH-1:0] keep_pop;
  logic [CNT_WIDTH:0]   byte_sum;

  always_comb begin
    keep_pop = '0;
    for (int unsigned i = 0; i < TDATA_WIDTH; i++)
      keep_pop = keep_pop + CNT_WIDTH'(s_tkeep[i]);
  end

  assign byte_sum = {1'b0, byte_cnt} + {1'b0, keep_pop};

  always_ff @(posedge clk) begin
    if (reset)
      byte_cnt <= '0;
    else if (state == IDLE && start && !stop)
      byte_cnt <= '0;
    else if (beat)
      byte_cnt <= byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      limit_q      <= '0;
      ipg_q        <= '0;
      gap_cnt      <= '0;
      stop_pending <= 1'b0;
      in_pkt       <= 1'b0;
      pkt_cnt      <= '0;
      word_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            limit_q      <= pkt_limit;
            ipg_q        <= ipg_cycles;
            pkt_cnt      <= '0;
            word_cnt     <= '0;
            stop_pending <= 1'b0;
            in_pkt       <= 1'b0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (beat) begin
            word_cnt <= (&word_cnt) ? word_cnt : word_cnt + CNT_WIDTH'(1);
            in_pkt   <= ~s_tlast;
          end
          if (eop) begin
            pkt_cnt <= pkt_cnt_p1[CNT_WIDTH] ? pkt_cnt : pkt_cnt_p1[CNT_WIDTH-1:0];
            if (limit_hit || stop_pending || stop) begin
              state <= DONE;
            end else if (ipg_q != '0) begin
              gap_cnt <= ipg_q;
              state   <= GAP;
            end
          end else if (stop) begin
            // Only a stop between packets ends the run now; otherwise the packet is finished first.
            if (!in_pkt && !beat)
              state <= DONE;
            else
              stop_pending <= 1'b1;
          end
        end
        GAP: begin
          if (stop) begin
            gap_cnt <= '0;
            state   <= DONE;
          end else if (gap_cnt <= IPG_WIDTH'(1)) begin
            gap_cnt <= '0;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt - IPG_WIDTH'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
